// File: rtl/rc4_pkg.sv
// Shared constants and FSM encoding for the nibble-RC4 encrypt/decrypt datapaths.
package rc4_pkg;
  localparam int W           = 4;
  localparam int SBOX_N      = 1 << W;
  localparam int KEY_LEN     = 4;
  localparam int MSG_LEN     = 8;
  localparam int INIT_CYCLES = SBOX_N;
  localparam int KSA_CYCLES  = 2 * SBOX_N;
  localparam int PRGA_CYCLES = 3 * MSG_LEN;

  typedef logic [W-1:0] nib_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_KSA_A, ST_KSA_B, ST_P_A, ST_P_B, ST_P_C, ST_DONE
  } state_e;
endpackage

// File: rtl/rc4_sbox16.sv
// 16x4 S-box register file: two async read ports, init write port, single-cycle swap.
module rc4_sbox16
  import rc4_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  nib_t rd_a_addr_i,
  output nib_t rd_a_data_o,
  input  nib_t rd_b_addr_i,
  output nib_t rd_b_data_o,
  input  logic wr_en_i,
  input  nib_t wr_addr_i,
  input  nib_t wr_data_i,
  input  logic swap_en_i,
  input  nib_t swap_i_i,
  input  nib_t swap_j_i
);
  nib_t mem_q [SBOX_N];

  assign rd_a_data_o = mem_q[rd_a_addr_i];
  assign rd_b_data_o = mem_q[rd_b_addr_i];

  // Both swap writes read the old contents; i==j naturally leaves the entry unchanged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < SBOX_N; k++) mem_q[k] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end else if (swap_en_i) begin
      mem_q[swap_i_i] <= mem_q[swap_j_i];
      mem_q[swap_j_i] <= mem_q[swap_i_i];
    end
  end
endmodule

// File: rtl/rc4_nibble_decryptor.sv
// Nibble-RC4 decryptor: KSA over a 4-nibble key, PRGA keystream XORed over 8 ct nibbles.
module rc4_nibble_decryptor
  import rc4_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEY_LEN*W-1:0]   key_in,
  input  logic [MSG_LEN*W-1:0]   ct_in,
  input  logic [3:0]             add_to_read,
  output logic [W-1:0]           out,
  output logic [MSG_LEN*W-1:0]   final_out,
  output logic                   busy,
  output logic                   done
);
  state_e state_q, state_d;
  nib_t   i_q, i_d, j_q, j_d, c_q, c_d, si_q, si_d;
  logic [2:0] n_q, n_d;
  logic [KEY_LEN-1:0][W-1:0] key_q;
  logic [MSG_LEN-1:0][W-1:0] ct_q, buf_q, buf_d;
  logic cap_en, wr_en, swap_en;
  nib_t rd_a_addr, rd_a_data, rd_b_addr, rd_b_data, ks;

  // In P_C port A reads S[j]; S[i] was latched in P_B, so port B can fetch S[t].
  assign rd_a_addr = (state_q == ST_P_C) ? j_q : i_q;
  assign rd_b_addr = si_q + rd_a_data;
  // Post-swap lookup: S'[i]=S[j], S'[j]=S[i], otherwise the untouched entry.
  assign ks = (rd_b_addr == i_q) ? rd_a_data :
              (rd_b_addr == j_q) ? si_q : rd_b_data;

  rc4_sbox16 u_sbox (
    .clk_i       (clk),
    .reset_i     (reset),
    .rd_a_addr_i (rd_a_addr),
    .rd_a_data_o (rd_a_data),
    .rd_b_addr_i (rd_b_addr),
    .rd_b_data_o (rd_b_data),
    .wr_en_i     (wr_en),
    .wr_addr_i   (c_q),
    .wr_data_i   (c_q),
    .swap_en_i   (swap_en),
    .swap_i_i    (i_q),
    .swap_j_i    (j_q)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    c_d     = c_q;
    n_d     = n_q;
    si_d    = si_q;
    buf_d   = buf_q;
    cap_en  = 1'b0;
    wr_en   = 1'b0;
    swap_en = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_INIT;
          c_d     = '0;
          cap_en  = 1'b1;
        end
      end
      ST_INIT: begin
        wr_en = 1'b1;
        i_d   = '0;
        j_d   = '0;
        n_d   = '0;
        buf_d = '0;
        c_d   = c_q + 1'b1;
        if (c_q == nib_t'(INIT_CYCLES - 1)) state_d = ST_KSA_A;
      end
      ST_KSA_A: begin
        j_d     = j_q + rd_a_data + key_q[i_q[$clog2(KEY_LEN)-1:0]];
        state_d = ST_KSA_B;
      end
      ST_KSA_B: begin
        swap_en = 1'b1;
        i_d     = i_q + 1'b1;
        if (i_q == nib_t'(SBOX_N - 1)) begin
          j_d     = '0;
          state_d = ST_P_A;
        end else begin
          state_d = ST_KSA_A;
        end
      end
      ST_P_A: begin
        i_d     = i_q + 1'b1;
        state_d = ST_P_B;
      end
      ST_P_B: begin
        j_d     = j_q + rd_a_data;
        si_d    = rd_a_data;
        state_d = ST_P_C;
      end
      ST_P_C: begin
        swap_en     = 1'b1;
        buf_d[n_q]  = ct_q[n_q] ^ ks;
        n_d         = n_q + 3'd1;
        state_d     = (n_q == 3'(MSG_LEN - 1)) ? ST_DONE : ST_P_A;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
      si_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      c_q     <= c_d;
      n_q     <= n_d;
      si_q    <= si_d;
      buf_q   <= buf_d;
      if (cap_en) begin
        key_q <= key_in;
        ct_q  <= ct_in;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign final_out = buf_q;
  assign out       = add_to_read[3] ? '0 : buf_q[add_to_read[2:0]];
endmodule

// File: tb/tb_rc4_nibble_decryptor.sv
// Randomized self-checking bench for rc4_nibble_decryptor against an array-based RC4 model.
module tb_rc4_nibble_decryptor;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] key_in;
  logic [31:0] ct_in;
  logic [3:0]  add_to_read;
  logic [3:0]  out;
  logic [31:0] final_out;
  logic        busy, done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic        busy_log [0:127];
  logic        done_log [0:127];
  logic [31:0] fo_log   [0:127];
  logic [31:0] K0;

  always #5 clk = ~clk;

  rc4_nibble_decryptor dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in), .ct_in(ct_in),
    .add_to_read(add_to_read), .out(out), .final_out(final_out),
    .busy(busy), .done(done)
  );

  // Textbook RC4 on a 16-entry nibble S-box.
  function automatic logic [31:0] ref_xor(input logic [15:0] key, input logic [31:0] ct);
    int s [16];
    int i, j, t, k;
    logic [31:0] r;
    for (int c = 0; c < 16; c++) s[c] = c;
    j = 0;
    for (int c = 0; c < 16; c++) begin
      j = (j + s[c] + int'((key >> (4 * (c % 4))) & 16'hF)) % 16;
      t = s[c]; s[c] = s[j]; s[j] = t;
    end
    i = 0; j = 0; r = ct;
    for (int n = 0; n < 8; n++) begin
      i = (i + 1) % 16;
      j = (j + s[i]) % 16;
      t = s[i]; s[i] = s[j]; s[j] = t;
      k = s[(s[i] + s[j]) % 16];
      r[4*n +: 4] = ct[4*n +: 4] ^ 4'(k);
    end
    return r;
  endfunction

  // Starts a run from a negedge; edge e is the e-th posedge after the one sampling start.
  task automatic run_op(input logic [15:0] key, input logic [31:0] ct, input bit extra_start,
                        input bit scramble, output logic [31:0] res, output int done_edge);
    @(negedge clk);
    key_in = key; ct_in = ct; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_log[0] = busy; done_log[0] = done; fo_log[0] = final_out;
    done_edge = -1;
    for (int e = 1; e < 120; e++) begin
      @(negedge clk);
      busy_log[e] = busy; done_log[e] = done; fo_log[e] = final_out;
      if (done) begin
        done_edge = e;
        break;
      end
      start = extra_start && (e == 19);
      if (scramble && e == 5) begin
        key_in = 16'($urandom);
        ct_in  = $urandom;
      end
    end
    start = 1'b0;
    res = final_out;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    logic [15:0] key;
    logic [31:0] ct;
    chk_cnt++;
    if ({busy, done} !== 2'b00 || final_out !== 32'h0) $display("FAIL por_state busy=%b done=%b fo=%h want 0 0 0", busy, done, final_out);
    else pass_cnt++;
    for (int pass = 0; pass < 2; pass++) begin
      key = 16'($urandom); ct = $urandom | 32'h1111_1111;
      @(negedge clk);
      key_in = key; ct_in = ct; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (pass == 0 ? 29 : 67) @(negedge clk);
      if (pass == 1) begin
        // nibbles 0..5 are written by edge 67
        exp = ref_xor(key, ct) & 32'h00FF_FFFF;
        chk_cnt++;
        if (final_out !== exp) $display("FAIL partial_prga fo=%h want %h", final_out, exp);
        else pass_cnt++;
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_cnt++;
      if ({busy, done} !== 2'b00 || final_out !== 32'h0)
        $display("FAIL reset_abort%0d busy=%b done=%b fo=%h want 0 0 0", pass, busy, done, final_out);
      else pass_cnt++;
      for (int a = 0; a < 16; a++) begin
        add_to_read = 4'(a);
        #1;
        chk_cnt++;
        if (out !== 4'h0) $display("FAIL reset_out addr=%0d out=%h want 0", a, out);
        else pass_cnt++;
      end
      repeat (4) @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_stays_idle busy=%b want 0", busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_latency();
    logic [31:0] res;
    int de;
    K0 = ref_xor(16'h0000, 32'h0);
    run_op(16'h0000, 32'h0, 1'b0, 1'b0, res, de);
    chk_cnt++;
    if (de !== 72) $display("FAIL latency done_edge=%0d want 72", de);
    else pass_cnt++;
    for (int e = 0; e < 72; e++) begin
      chk_cnt++;
      if ({busy_log[e], done_log[e]} !== 2'b10)
        $display("FAIL busy_window edge=%0d busy=%b done=%b want 1 0", e, busy_log[e], done_log[e]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (busy_log[72] !== 1'b0) $display("FAIL busy_at_done busy=%b want 0", busy_log[72]);
    else pass_cnt++;
    chk_cnt++;
    if (res !== K0) $display("FAIL keystream_key0 fo=%h want %h", res, K0);
    else pass_cnt++;
  endtask

  task automatic test_involution();
    logic [31:0] r, r2, exp;
    int de;
    exp = ref_xor(16'hA5C3, 32'h0123_4567);
    run_op(16'hA5C3, 32'h0123_4567, 1'b0, 1'b0, r, de);
    chk_cnt++;
    if (r !== exp) $display("FAIL invol_fwd fo=%h want %h", r, exp);
    else pass_cnt++;
    run_op(16'hA5C3, r, 1'b0, 1'b0, r2, de);
    chk_cnt++;
    if (r2 !== 32'h0123_4567) $display("FAIL invol_back fo=%h want 01234567", r2);
    else pass_cnt++;
  endtask

  task automatic test_keystream_zero();
    logic [31:0] r, ks;
    logic [15:0] key;
    int de;
    run_op(16'h0000, K0, 1'b0, 1'b0, r, de);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL ks_zero fo=%h want 0", r);
    else pass_cnt++;
    for (int a = 0; a < 10; a++) begin
      if (a == 8) continue;
      add_to_read = 4'(a);
      #1;
      chk_cnt++;
      if (out !== 4'h0) $display("FAIL ks_zero_out addr=%0d out=%h want 0", a, out);
      else pass_cnt++;
    end
    key = 16'($urandom);
    ks  = ref_xor(key, 32'h0);
    run_op(key, ks, 1'b0, 1'b0, r, de);
    chk_cnt++;
    if (r !== 32'h0) $display("FAIL ks_zero_rand key=%h fo=%h want 0", key, r);
    else pass_cnt++;
  endtask

  task automatic test_start_handling();
    logic [31:0] r, exp, ct;
    logic [15:0] key;
    int de;
    key = 16'($urandom); ct = $urandom;
    exp = ref_xor(key, ct);
    run_op(key, ct, 1'b1, 1'b1, r, de);
    chk_cnt++;
    if (de !== 72) $display("FAIL start_ignored done_edge=%0d want 72", de);
    else pass_cnt++;
    chk_cnt++;
    if (r !== exp) $display("FAIL capture_hold fo=%h want %h", r, exp);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    logic [31:0] r, exp, ct;
    logic [15:0] key;
    int de;
    run_op(16'h1234, 32'hDEAD_BEEF, 1'b0, 1'b0, r, de);
    key = 16'($urandom); ct = $urandom;
    exp = ref_xor(key, ct);
    run_op(key, ct, 1'b0, 1'b0, r, de);
    chk_cnt++;
    if ({busy_log[0], done_log[0]} !== 2'b10)
      $display("FAIL restart_done_drop busy=%b done=%b want 1 0", busy_log[0], done_log[0]);
    else pass_cnt++;
    chk_cnt++;
    if (fo_log[1] !== 32'h0) $display("FAIL restart_clear fo=%h want 0", fo_log[1]);
    else pass_cnt++;
    chk_cnt++;
    if (de !== 72 || r !== exp) $display("FAIL restart_result edge=%0d fo=%h want 72 %h", de, r, exp);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] r, exp, ct;
    logic [15:0] key;
    logic [3:0]  eo;
    int de, a;
    for (int it = 0; it < 8; it++) begin
      key = 16'($urandom); ct = $urandom;
      exp = ref_xor(key, ct);
      run_op(key, ct, 1'b0, 1'b0, r, de);
      chk_cnt++;
      if (r !== exp) $display("FAIL random%0d key=%h ct=%h fo=%h want %h", it, key, ct, r, exp);
      else pass_cnt++;
      for (int q = 0; q < 3; q++) begin
        a = $urandom_range(0, 15);
        eo = (a < 8) ? exp[4*a +: 4] : 4'h0;
        add_to_read = 4'(a);
        #1;
        chk_cnt++;
        if (out !== eo) $display("FAIL random_out addr=%0d out=%h want %h", a, out, eo);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_in = '0; ct_in = '0; add_to_read = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_involution();
    test_keystream_zero();
    test_start_handling();
    test_restart();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
